// File: rtl/byte_sequencer_if.sv
// Byte sequencer handshake bundle: word-in stream and byte-out stream.
// slave = the sequencer, master = whoever drives words in and drains bytes out.
interface byte_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        in_msb_first;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    modport slave (
        input  in_valid, in_data, in_len, in_msb_first, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );

    modport master (
        output in_valid, in_data, in_len, in_msb_first, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/byte_sequencer.sv
// Splits 32-bit words into 1..4 bytes, LSB- or MSB-first, with a wrapping
// count of bytes accepted downstream.
module byte_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    byte_sequencer_if.slave      bus,
    output logic [CNT_W-1:0]     bytes_sent
);
    typedef enum logic {IDLE, SEND} state_e;

    state_e             state_q, state_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         len_q, len_d;
    logic               msb_q, msb_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sending;
    logic [1:0]         final_idx;
    logic               last_idx;
    logic               in_fire;
    logic               out_fire;

    assign sending   = (state_q == SEND);
    assign final_idx = msb_q ? (2'd3 - len_q) : len_q;
    assign last_idx  = sending && (idx_q == final_idx);

    assign bus.out_valid = sending;
    assign bus.out_last  = last_idx;
    assign bus.out_byte  = sending ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;
    // Accepting on the last byte's handshake lets words chain with no bubble.
    assign bus.in_ready  = sending ? (last_idx & bus.out_ready) : 1'b1;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = sending & bus.out_ready;

    assign bytes_sent = cnt_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, out_fire};
        if (in_fire) begin
            state_d = SEND;
            data_d  = bus.in_data;
            len_d   = bus.in_len;
            msb_d   = bus.in_msb_first;
            idx_d   = bus.in_msb_first ? 2'd3 : 2'd0;
        end else if (out_fire) begin
            if (last_idx)
                state_d = IDLE;
            else
                idx_d = msb_q ? (idx_q - 2'd1) : (idx_q + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_byte_sequencer.sv
// Directed bench for byte_sequencer; a CNT_W=2 twin shares the stimulus for wrap checks.
module tb_byte_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] bs;
    logic [1:0]  bs2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_sequencer_if bus0();
    byte_sequencer_if bus1();

    assign bus1.in_valid     = bus0.in_valid;
    assign bus1.in_data      = bus0.in_data;
    assign bus1.in_len       = bus0.in_len;
    assign bus1.in_msb_first = bus0.in_msb_first;
    assign bus1.out_ready    = bus0.out_ready;

    byte_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .bytes_sent(bs)
    );
    byte_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .bytes_sent(bs2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [1:0] l, input logic m);
        bus0.in_valid     = 1'b1;
        bus0.in_data      = d;
        bus0.in_len       = l;
        bus0.in_msb_first = m;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] b, input logic last,
                           input logic [15:0] cnt);
        chk({tag, "_valid"}, {31'd0, bus0.out_valid}, 32'd1);
        chk({tag, "_byte"},  {24'd0, bus0.out_byte}, {24'd0, b});
        chk({tag, "_last"},  {31'd0, bus0.out_last}, {31'd0, last});
        chk({tag, "_cnt"},   {16'd0, bs}, {16'd0, cnt});
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] cnt, input logic [1:0] cnt2);
        chk({tag, "_valid"}, {31'd0, bus0.out_valid}, 32'd0);
        chk({tag, "_last"},  {31'd0, bus0.out_last}, 32'd0);
        chk({tag, "_byte"},  {24'd0, bus0.out_byte}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, bus0.in_ready}, 32'd1);
        chk({tag, "_cnt"},   {16'd0, bs}, {16'd0, cnt});
        chk({tag, "_cnt2"},  {30'd0, bs2}, {30'd0, cnt2});
    endtask

    logic [7:0] e31 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] e33 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        rst_n = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.in_data = '0;
        bus0.in_len = '0;
        bus0.in_msb_first = 1'b0;
        bus0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_idle("in_rst", 16'd0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk_idle("post_rst", 16'd0, 2'd0);

        // 12345678, 4 bytes MSB first
        @(negedge clk);
        drive_word(32'h12345678, 2'd3, 1'b1);
        bus0.out_ready = 1'b1;
        #1 chk("t31_rdy_idle", {31'd0, bus0.in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus0.in_valid = 1'b0;
            #1;
            chk_out("t31", e31[k], k == 3, 16'(k));
            chk("t31_cnt2", {30'd0, bs2}, 32'(k % 4));
        end
        @(negedge clk); #1;
        chk_idle("t31_end", 16'd4, 2'd0);

        // same word, 2 bytes LSB first
        @(negedge clk);
        drive_word(32'h12345678, 2'd1, 1'b0);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1 chk_out("t32_b0", 8'h78, 1'b0, 16'd4);
        @(negedge clk); #1;
        chk_out("t32_b1", 8'h56, 1'b1, 16'd5);
        chk("t32_cnt2", {30'd0, bs2}, 32'd1);
        @(negedge clk); #1;
        chk_idle("t32_end", 16'd6, 2'd2);

        // back-to-back words; second word held on the bus while the first drains
        @(negedge clk);
        drive_word(32'hAABBCCDD, 2'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_word(32'h000000EE, 2'd0, 1'b0);
            #1;
            chk_out("t33", e33[k], k == 3, 16'(6 + k));
            chk("t33_rdy", {31'd0, bus0.in_ready}, {31'd0, k == 3});
        end
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1 chk_out("t33_ee", 8'hEE, 1'b1, 16'd10);
        chk("t33_rdy_ee", {31'd0, bus0.in_ready}, 32'd1);
        @(negedge clk); #1;
        chk_idle("t33_end", 16'd11, 2'd3);

        // stall on BB for 3 cycles
        @(negedge clk);
        drive_word(32'hAABBCCDD, 2'd3, 1'b1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1 chk_out("t34_aa", 8'hAA, 1'b0, 16'd11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus0.out_ready = 1'b0;
            #1;
            chk_out("t34_stall", 8'hBB, 1'b0, 16'd12);
            chk("t34_rdy", {31'd0, bus0.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus0.out_ready = 1'b1;
        #1 chk_out("t34_bb", 8'hBB, 1'b0, 16'd12);
        @(negedge clk); #1;
        chk_out("t34_cc", 8'hCC, 1'b0, 16'd13);
        @(negedge clk); #1;
        chk_out("t34_dd", 8'hDD, 1'b1, 16'd14);
        @(negedge clk); #1;
        chk_idle("t34_end", 16'd15, 2'd3);

        // reset mid-word discards the rest of it
        @(negedge clk);
        drive_word(32'hDEADBEEF, 2'd3, 1'b1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1 chk_out("t35_de", 8'hDE, 1'b0, 16'd15);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_idle("t35_rst", 16'd0, 2'd0);
        drive_word(32'h00000001, 2'd0, 1'b0);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1 chk_out("t35_01", 8'h01, 1'b1, 16'd0);
        @(negedge clk); #1;
        chk_idle("t35_end", 16'd1, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_sequencer.md
BYTE_SEQUENCER -- requirements
Module: byte_sequencer

Interface
REQ-001 Parameter: CNT_W, default 16, width of the sent-byte counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  32  word to split; byte k = in_data[8k+7:8k].
REQ-007 in_len  input  2  number of bytes to emit minus 1 (0 = 1 byte, 3 = 4 bytes).
REQ-008 in_msb_first  input  1  1 = emit byte 3 first and count down; 0 = emit byte 0 first and count up.
REQ-009 out_valid  output  1  out_byte is valid.
REQ-010 out_ready  input  1  downstream accepts out_byte.
REQ-011 out_byte  output  8  current byte.
REQ-012 out_last  output  1  out_byte is the final byte of the current word.
REQ-013 bytes_sent  output  CNT_W  count of accepted output bytes, wraps modulo 2^CNT_W.

Function
REQ-014 Two states: IDLE (no word held) and SEND (word held, emitting bytes).
REQ-015 Input transfer occurs when in_valid and in_ready are both 1 on a rising edge; output transfer occurs when out_valid and out_ready are both 1.
REQ-016 In IDLE: in_ready = 1, out_valid = 0.
REQ-017 On an input transfer, capture in_data, in_len and in_msb_first into holding registers, go to SEND, and present the first byte on the next cycle (latency 1 cycle, in to first out_valid).
REQ-018 First byte index: 3 when msb_first = 1, else 0; with in_len = L, the final index is 3-L when msb_first = 1, else L.
REQ-019 In SEND: out_valid = 1; out_byte = held byte at the current index; out_last = 1 only at the final index.
REQ-020 A stalled output (out_valid = 1, out_ready = 0) holds out_byte, out_last and the index stable.
REQ-021 An output transfer of a non-last byte advances the index by one in the selected direction.
REQ-022 In SEND: in_ready = out_last AND out_ready, combinational.
REQ-023 Last-byte output transfer with no simultaneous input transfer: go to IDLE.
REQ-024 Last-byte output transfer with a simultaneous input transfer: capture the new word and stay in SEND, so the new word's first byte is valid next cycle with no bubble.
REQ-025 Holding registers change only on an input transfer; in_data, in_len and in_msb_first are ignored at all other times.
REQ-026 bytes_sent increments by 1 on every output transfer; it wraps from 2^CNT_W-1 to 0.
REQ-027 Sustained throughput: one byte per cycle while out_ready = 1 and words arrive back-to-back.

Reset
REQ-028 While rst_n = 0 at a rising edge, the block enters IDLE and sets bytes_sent = 0, the index = 0 and the holding registers = 0.
REQ-029 During and directly after reset: out_valid = 0, out_last = 0, out_byte = 8'h00, in_ready = 1.
REQ-030 Reset asserted mid-word (SEND) discards the held word; no further bytes of it are emitted.

Verification
REQ-031 in_data=32'h12345678, len=3, msb_first=1, out_ready=1 -> out_byte 12,34,56,78 on 4 consecutive cycles starting 1 cycle after the input transfer; out_last only with 78; bytes_sent=4.
REQ-032 Same word with msb_first=0, len=1 -> 78,56 then IDLE; out_last with 56; bytes_sent=2.
REQ-033 Back-to-back words 32'hAABBCCDD (len=3, msb) and 32'h000000EE (len=0) -> AA,BB,CC,DD,EE on 5 consecutive cycles; in_ready=1 only in the DD cycle.
REQ-034 out_ready held 0 for 3 cycles on byte BB -> BB stable for those 3 cycles, in_ready=0, bytes_sent unchanged; resumes CC after out_ready=1.
REQ-035 rst_n=0 for 1 cycle after the first byte of 32'hDEADBEEF -> next cycle out_valid=0, bytes_sent=0, in_ready=1; a following word 32'h01 (len=0) emits 01.
REQ-036 With CNT_W=2, emit 5 bytes -> bytes_sent goes 1,2,3,0,1.
